// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline: WB control bit positions, the
// hard-wired zero register index, and default datapath widths.
package mips_pkg;

  localparam int MIPS_DATA_W = 32;
  localparam int MIPS_ADDR_W = 5;

  // Bit positions inside the 2-bit WB control field carried by MEM/WB.
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_core.sv
// Raw 2^ADDR_W x DATA_W storage with one write port and three combinational
// read ports (A, B, debug); no bypass or $0 masking, cleared by async reset.
module regfile_core #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (we) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign ra_data = regs_q[ra_addr];
  assign rb_data = regs_q[rb_addr];
  assign rd_data = regs_q[rd_addr];

endmodule

// File: rtl/wb_regfile.sv
// MIPS write-back stage plus architectural register file: WB mux, $0 guard,
// same-cycle write-through bypass on ID reads, committed-write counter.
module wb_regfile
  import mips_pkg::*;
#(
  parameter int DATA_W = MIPS_DATA_W,
  parameter int ADDR_W = MIPS_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        control_wb,
  input  logic [DATA_W-1:0] Read_data,
  input  logic [DATA_W-1:0] ALU_result,
  input  logic [ADDR_W-1:0] Write_reg,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_reg_write,
  output logic [ADDR_W-1:0] wb_write_reg,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [31:0]       write_count
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] raw_rs;
  logic [DATA_W-1:0] raw_rt;
  logic [DATA_W-1:0] raw_dbg;
  logic [31:0]       write_count_q;
  logic [31:0]       write_count_d;

  assign wb_data      = control_wb[WB_MEMTOREG] ? Read_data : ALU_result;
  // Reset gates the write enable so the bypass cannot leak uncommitted data.
  assign wb_reg_write = !reset && control_wb[WB_REGWRITE] && (Write_reg != ZERO_IDX);
  assign wb_write_reg = Write_reg;

  regfile_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .we      (wb_reg_write),
    .waddr   (Write_reg),
    .wdata   (wb_data),
    .ra_addr (rs_addr),
    .ra_data (raw_rs),
    .rb_addr (rt_addr),
    .rb_data (raw_rt),
    .rd_addr (dbg_addr),
    .rd_data (raw_dbg)
  );

  always_comb begin
    rs_data = raw_rs;
    rt_data = raw_rt;
    if (rs_addr == ZERO_IDX) begin
      rs_data = '0;
    end else if (wb_reg_write && (Write_reg == rs_addr)) begin
      rs_data = wb_data;
    end
    if (rt_addr == ZERO_IDX) begin
      rt_data = '0;
    end else if (wb_reg_write && (Write_reg == rt_addr)) begin
      rt_data = wb_data;
    end
  end

  assign dbg_data = (dbg_addr == ZERO_IDX) ? '0 : raw_dbg;

  always_comb begin
    write_count_d = write_count_q;
    if (wb_reg_write) begin
      write_count_d = write_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_count_q <= '0;
    end else begin
      write_count_q <= write_count_d;
    end
  end

  assign write_count = write_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed-vector bench for wb_regfile: write-back mux, bypass, $0 guard,
// commit latency, counter and asynchronous reset behaviour.
module tb_wb_regfile;

  logic        clk;
  logic        reset;
  logic [1:0]  control_wb;
  logic [31:0] Read_data;
  logic [31:0] ALU_result;
  logic [4:0]  Write_reg;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] wb_data;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [31:0] write_count;

  int n_checks = 0;
  int n_fails  = 0;

  wb_regfile #(
    .DATA_W (32),
    .ADDR_W (5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .control_wb   (control_wb),
    .Read_data    (Read_data),
    .ALU_result   (ALU_result),
    .Write_reg    (Write_reg),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .wb_data      (wb_data),
    .wb_reg_write (wb_reg_write),
    .wb_write_reg (wb_write_reg),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data),
    .write_count  (write_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled
  // in the quiet part of the cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    control_wb = 2'b10;
    Read_data  = 32'h0000_00AB;
    ALU_result = 32'h0000_00CD;
    Write_reg  = 5'd4;
    rs_addr    = 5'd4;
    rt_addr    = 5'd0;
    dbg_addr   = 5'd4;

    // Reset held: enable forced low, no bypass, no commit.
    step();
    step();
    #1;
    chk("rst_wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
    chk("rst_rs_no_bypass", rs_data, 32'd0);
    chk("rst_wb_data_follows", wb_data, 32'h0000_00CD);
    chk("rst_count", write_count, 32'd0);
    chk("rst_dbg4", dbg_data, 32'd0);

    control_wb = 2'b00;
    reset      = 1'b0;
    step();

    // Reset then idle.
    rs_addr  = 5'd5;
    dbg_addr = 5'd31;
    #1;
    chk("idle_rs5", rs_data, 32'd0);
    chk("idle_dbg31", dbg_data, 32'd0);
    chk("idle_count", write_count, 32'd0);

    // ALU write-back to r8.
    control_wb = 2'b10;
    ALU_result = 32'h0000_1234;
    Write_reg  = 5'd8;
    dbg_addr   = 5'd8;
    #1;
    chk("alu_wb_data", wb_data, 32'h0000_1234);
    chk("alu_wb_reg_write", {31'd0, wb_reg_write}, 32'd1);
    chk("alu_wb_write_reg", {27'd0, wb_write_reg}, 32'd8);
    chk("alu_dbg8_pre", dbg_data, 32'd0);
    step();
    control_wb = 2'b00;
    #1;
    chk("alu_dbg8_post", dbg_data, 32'h0000_1234);
    chk("alu_count", write_count, 32'd1);

    // Load write-back to r9 with both ports bypassing.
    control_wb = 2'b11;
    Read_data  = 32'hDEAD_BEEF;
    ALU_result = 32'h0000_0001;
    Write_reg  = 5'd9;
    rs_addr    = 5'd9;
    rt_addr    = 5'd9;
    dbg_addr   = 5'd9;
    #1;
    chk("ld_wb_data", wb_data, 32'hDEAD_BEEF);
    chk("ld_rs_bypass", rs_data, 32'hDEAD_BEEF);
    chk("ld_rt_bypass", rt_data, 32'hDEAD_BEEF);
    chk("ld_dbg9_pre", dbg_data, 32'd0);
    step();
    control_wb = 2'b00;
    #1;
    chk("ld_dbg9_post", dbg_data, 32'hDEAD_BEEF);
    chk("ld_count", write_count, 32'd2);

    // Independent ports: rs bypasses r10, rt reads committed r8.
    control_wb = 2'b10;
    ALU_result = 32'h0000_AAAA;
    Write_reg  = 5'd10;
    rs_addr    = 5'd10;
    rt_addr    = 5'd8;
    #1;
    chk("ind_rs_bypass", rs_data, 32'h0000_AAAA);
    chk("ind_rt_regfile", rt_data, 32'h0000_1234);
    step();
    control_wb = 2'b00;
    rt_addr    = 5'd10;
    #1;
    chk("ind_rt_r10_post", rt_data, 32'h0000_AAAA);
    chk("ind_count", write_count, 32'd3);

    // $0 protection.
    control_wb = 2'b10;
    ALU_result = 32'hFFFF_FFFF;
    Write_reg  = 5'd0;
    rs_addr    = 5'd0;
    dbg_addr   = 5'd0;
    #1;
    chk("z_wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
    chk("z_rs0", rs_data, 32'd0);
    step();
    control_wb = 2'b00;
    #1;
    chk("z_dbg0", dbg_data, 32'd0);
    chk("z_count", write_count, 32'd3);

    // RegWrite low: no bypass, no commit.
    control_wb = 2'b01;
    Read_data  = 32'h0000_0055;
    Write_reg  = 5'd8;
    rs_addr    = 5'd8;
    dbg_addr   = 5'd8;
    #1;
    chk("nw_wb_data", wb_data, 32'h0000_0055);
    chk("nw_wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
    chk("nw_rs8", rs_data, 32'h0000_1234);
    step();
    control_wb = 2'b00;
    #1;
    chk("nw_dbg8", dbg_data, 32'h0000_1234);
    chk("nw_count", write_count, 32'd3);

    // Write r3 then reset between edges.
    control_wb = 2'b10;
    ALU_result = 32'h0000_0077;
    Write_reg  = 5'd3;
    dbg_addr   = 5'd3;
    step();
    control_wb = 2'b00;
    #1;
    chk("mr_dbg3_pre", dbg_data, 32'h0000_0077);
    chk("mr_count_pre", write_count, 32'd4);
    reset = 1'b1;
    #1;
    chk("mr_dbg3_async", dbg_data, 32'd0);
    chk("mr_count_async", write_count, 32'd0);
    chk("mr_rs8_async", rs_data, 32'd0);
    reset = 1'b0;
    step();

    // First commit after reset release.
    control_wb = 2'b10;
    ALU_result = 32'h0000_0005;
    Write_reg  = 5'd4;
    dbg_addr   = 5'd4;
    step();
    control_wb = 2'b00;
    #1;
    chk("post_dbg4", dbg_data, 32'h0000_0005);
    chk("post_count", write_count, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
